// File: rtl/mem_access_sequencer.sv
// Single-access sequencer in front of the 64x32 RAM: registers one request, then
// drives chip-select, address, data and direction in an order that cannot cause stray writes.
module mem_access_sequencer #(
  parameter int unsigned WAIT_CYCLES = 1,   // 1..15
  parameter int unsigned TIMEOUT     = 16   // 1..255
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        Request,
  input  logic        Request_Read_H_Write_L,
  input  logic [5:0]  Request_Address,
  input  logic [31:0] Request_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] Load_Data,
  output logic [6:0]  Mem_Address,
  output logic [31:0] Mem_DataIn,
  output logic        Mem_Read_H_Write_L,
  input  logic [31:0] Mem_DataOut,
  input  logic        Mem_MFC
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT_MFC,
    S_COMPLETE
  } state_e;

  state_e      state_q, state_d;
  logic        op_read_q, op_read_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [6:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] load_q, load_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // NOTE: every register is written with <= so all of them update from the same
  // pre-edge values; a blocking '=' here would let later lines see new values.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= S_IDLE;
      op_read_q  <= 1'b1;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      mem_addr_q <= 7'h40;
      mem_din_q  <= '0;
      mem_rw_q   <= 1'b1;
      load_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_read_q  <= op_read_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_rw_q   <= mem_rw_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    op_read_d  = op_read_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_rw_d   = mem_rw_q;
    load_d     = load_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Request) begin
          op_read_d  = Request_Read_H_Write_L;
          mem_addr_d = {1'b1, Request_Address};
          mem_din_d  = Request_Data;
          state_d    = S_SETUP;
        end
      end

      // Address and data have settled for a full cycle before select and direction move.
      S_SETUP: begin
        mem_addr_d[6] = 1'b0;
        mem_rw_d      = op_read_q;
        wait_cnt_d    = WAIT_LOAD;
        state_d       = S_ACCESS;
      end

      S_ACCESS: begin
        if (wait_cnt_q == 4'd0) begin
          to_cnt_d = '0;
          state_d  = S_WAIT_MFC;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      // Deselect and direction return happen on one edge, so a write never outlives select.
      S_WAIT_MFC: begin
        if (Mem_MFC) begin
          if (op_read_q) load_d = Mem_DataOut;
          mem_addr_d[6] = 1'b1;
          mem_rw_d      = 1'b1;
          done_d        = 1'b1;
          state_d       = S_COMPLETE;
        end else if (to_cnt_q == TO_LAST) begin
          mem_addr_d[6] = 1'b1;
          mem_rw_d      = 1'b1;
          error_d       = 1'b1;
          state_d       = S_COMPLETE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      S_COMPLETE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign Busy               = busy_q;
  assign Done               = done_q;
  assign Error              = error_q;
  assign Load_Data          = load_q;
  assign Mem_Address        = mem_addr_q;
  assign Mem_DataIn         = mem_din_q;
  assign Mem_Read_H_Write_L = mem_rw_q;

endmodule
